// File: rtl/golomb_pkg.sv
// Shared constants, state encoding and the merrval assembly helper for the
// Golomb-Rice decoder.
//   LIMIT  : maximum codeword length in bits
//   QBPP   : width of the escape (fixed-length) field
//   MERR_W : width of the decoded mapped error
//   QMAX   : longest unary prefix before the escape code is forced
package golomb_pkg;

  localparam int LIMIT  = 32;
  localparam int QBPP   = 8;
  localparam int MERR_W = 16;
  localparam int QMAX   = LIMIT - QBPP - 1;

  localparam int Q_W   = 5;
  localparam int R_W   = 14;
  localparam int K_W   = 4;
  localparam int CNT_W = 4;

  localparam logic [Q_W-1:0]   QMAX_Q   = 5'(QMAX);
  localparam logic [CNT_W-1:0] QBPP_CNT = 4'(QBPP);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UNARY = 3'd1,
    REM   = 3'd2,
    ESC   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // (q << k) | r evaluated at MERR_W+Q_W bits, then truncated to MERR_W.
  function automatic logic [MERR_W-1:0] golomb_combine(
    input logic [Q_W-1:0] q,
    input logic [R_W-1:0] r,
    input logic [K_W-1:0] k
  );
    logic [MERR_W+Q_W-1:0] wide;
    wide = ({{MERR_W{1'b0}}, q} << k) | {{(MERR_W+Q_W-R_W){1'b0}}, r};
    return wide[MERR_W-1:0];
  endfunction

endpackage

// File: rtl/golomb_bit_buffer.sv
// MSB-first byte-to-bit buffer feeding the Golomb-Rice decoder FSM.
//   in_valid/in_ready/in_data : byte load handshake (accepted only when empty)
//   bit_avail                 : at least one unread bit is held
//   bit_val                   : the next bit (MSB of the shift register)
//   consume                   : drop bit_val this cycle
// Leftover bits survive across codewords; only reset discards them.
module golomb_bit_buffer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       bit_avail,
  output logic       bit_val,
  input  logic       consume
);

  logic [7:0] sreg_r;
  logic [3:0] count_r;

  assign in_ready  = (count_r == 4'd0);
  assign bit_avail = (count_r != 4'd0);
  assign bit_val   = sreg_r[7];

  // Byte load when empty, otherwise shift out one bit per consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_r  <= 8'd0;
      count_r <= 4'd0;
    end else if (in_valid && in_ready) begin
      sreg_r  <= in_data;
      count_r <= 4'd8;
    end else if (consume && bit_avail) begin
      sreg_r  <= {sreg_r[6:0], 1'b0};
      count_r <= count_r - 4'd1;
    end else begin
      sreg_r  <= sreg_r;
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/golomb_rice_decoder.sv
// Bit-serial Golomb-Rice decoder (JPEG-LS regular-mode error decoding),
// including the LIMIT escape with a QBPP-bit fixed-length field.
//   req_valid/req_ready/k          : per-codeword Golomb parameter handshake
//   in_valid/in_ready/in_data      : MSB-first bitstream bytes
//   out_valid/out_ready/merrval/err: decoded mapped error; err flags a unary
//                                    prefix longer than QMAX zeros
module golomb_rice_decoder
  import golomb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [K_W-1:0]    k,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MERR_W-1:0] merrval,
  output logic              err
);

  state_t              state_r, state_nxt;
  logic [K_W-1:0]      k_r, k_nxt;
  logic [Q_W-1:0]      q_r, q_nxt;
  logic [R_W-1:0]      r_r, r_nxt;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt;
  logic [MERR_W-1:0]   merrval_r, merrval_nxt;
  logic                err_r, err_nxt;

  logic                bit_avail;
  logic                bit_val;
  logic                consume;
  logic [R_W-1:0]      r_shift;

  golomb_bit_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .bit_avail (bit_avail),
    .bit_val   (bit_val),
    .consume   (consume)
  );

  assign consume   = bit_avail && ((state_r == UNARY) || (state_r == REM) || (state_r == ESC));
  assign r_shift   = {r_r[R_W-2:0], bit_val};
  assign req_ready = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign merrval   = merrval_r;
  assign err       = err_r;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      k_r       <= 4'd0;
      q_r       <= 5'd0;
      r_r       <= 14'd0;
      cnt_r     <= 4'd0;
      merrval_r <= 16'd0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      k_r       <= k_nxt;
      q_r       <= q_nxt;
      r_r       <= r_nxt;
      cnt_r     <= cnt_nxt;
      merrval_r <= merrval_nxt;
      err_r     <= err_nxt;
    end
  end

  // Next-state and datapath update; every register holds unless a bit is
  // consumed or a handshake completes, which gives the input-stall behaviour.
  always_comb begin
    state_nxt   = state_r;
    k_nxt       = k_r;
    q_nxt       = q_r;
    r_nxt       = r_r;
    cnt_nxt     = cnt_r;
    merrval_nxt = merrval_r;
    err_nxt     = err_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          k_nxt     = k;
          q_nxt     = 5'd0;
          r_nxt     = 14'd0;
          cnt_nxt   = 4'd0;
          state_nxt = UNARY;
        end else begin
          state_nxt = IDLE;
        end
      end
      UNARY: begin
        if (!bit_avail) begin
          state_nxt = UNARY;
        end else if (!bit_val) begin
          if (q_r == QMAX_Q) begin
            err_nxt     = 1'b1;
            merrval_nxt = 16'd0;
            state_nxt   = DONE;
          end else begin
            q_nxt = q_r + 5'd1;
          end
        end else if (q_r == QMAX_Q) begin
          // Terminating '1' after QMAX zeros introduces the escape field.
          cnt_nxt   = QBPP_CNT;
          state_nxt = ESC;
        end else if (k_r == 4'd0) begin
          merrval_nxt = {{(MERR_W-Q_W){1'b0}}, q_r};
          state_nxt   = DONE;
        end else begin
          cnt_nxt   = k_r;
          state_nxt = REM;
        end
      end
      REM: begin
        if (bit_avail) begin
          r_nxt   = r_shift;
          cnt_nxt = cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            merrval_nxt = golomb_combine(q_r, r_shift, k_r);
            state_nxt   = DONE;
          end else begin
            state_nxt = REM;
          end
        end else begin
          state_nxt = REM;
        end
      end
      ESC: begin
        if (bit_avail) begin
          r_nxt   = r_shift;
          cnt_nxt = cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            // Escape field carries MErrval-1.
            merrval_nxt = {{(MERR_W-R_W){1'b0}}, r_shift} + 16'd1;
            state_nxt   = DONE;
          end else begin
            state_nxt = ESC;
          end
        end else begin
          state_nxt = ESC;
        end
      end
      DONE: begin
        if (out_ready) begin
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
